// File: rtl/riscv_div_pkg.sv
// Shared decode constants and the divide-op decoder for the EX-stage divider.
package riscv_div_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OP_32 = 7'b0111011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [1:0] RV32I     = 2'd1;

  typedef struct packed {
    logic is_div;  // DIV/DIVU/REM/REMU(+W) and allowed in current mode
    logic w;       // 32-bit W variant
    logic sgn;     // signed op
    logic rem;     // remainder wanted
  } div_op_t;

  // funct3[2] selects the divide half of the M extension; [1]=rem, [0]=unsigned.
  function automatic div_op_t div_decode(input logic [31:0] instr, input logic [1:0] st_xlen);
    div_op_t d;
    logic [2:0] f3;
    logic [6:0] opc;
    f3       = instr[14:12];
    opc      = instr[6:0];
    d.w      = (opc == OPC_OP_32);
    d.sgn    = ~f3[0];
    d.rem    = f3[1];
    d.is_div = (instr[31:25] == F7_MULDIV) && f3[2] &&
               ((opc == OPC_OP) || ((opc == OPC_OP_32) && (st_xlen != RV32I)));
    return d;
  endfunction

endpackage

// File: rtl/riscv_div_if.sv
// Pipeline <-> divider signal bundle.
interface riscv_div_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
);
  logic            ex_stall;
  logic            div_stall;
  logic            id_bubble;
  logic [ILEN-1:0] id_instr;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic [1:0]      st_xlen;
  logic            div_bubble;
  logic [XLEN-1:0] div_r;

  modport master (
    output ex_stall, id_bubble, id_instr, opA, opB, st_xlen,
    input  div_stall, div_bubble, div_r
  );

  modport slave (
    input  ex_stall, id_bubble, id_instr, opA, opB, st_xlen,
    output div_stall, div_bubble, div_r
  );
endinterface

// File: rtl/riscv_div.sv
// Iterative radix-2 restoring divider for RV32M/RV64M DIV/DIVU/REM/REMU(+W).
module riscv_div
  import riscv_div_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  riscv_div_if.slave bus
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvd;     // dividend shifting out at the top, quotient bits entering at the bottom
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] rem;
  logic            neg_q, neg_r, op_w, op_rem;

  div_op_t         dec;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_int, min_w;
  logic            s_a, s_b, dz, ovf;
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] rem_nx, q_fix, r_fix, res;

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sx);
    logic [XLEN-1:0] r;
    r       = (sx & v[31]) ? '1 : '0;
    r[31:0] = v;
    return r;
  endfunction

  // Decode and operand conditioning: width extension, magnitudes, special cases.
  always_comb begin
    dec              = div_decode(bus.id_instr[31:0], bus.st_xlen);
    min_int          = '0;
    min_int[XLEN-1]  = 1'b1;
    min_w            = ext32(32'h8000_0000, 1'b1);
    a_ext            = bus.opA;
    b_ext            = bus.opB;
    if (dec.w) begin
      a_ext = ext32(bus.opA[31:0], dec.sgn);
      b_ext = ext32(bus.opB[31:0], dec.sgn);
    end
    s_a   = dec.sgn & a_ext[XLEN-1];
    s_b   = dec.sgn & b_ext[XLEN-1];
    a_mag = s_a ? -a_ext : a_ext;
    b_mag = s_b ? -b_ext : b_ext;
    dz    = (b_ext == '0);
    ovf   = dec.sgn && (b_ext == '1) && (a_ext == (dec.w ? min_w : min_int));
  end

  // One restoring step plus final sign fix / result selection.
  always_comb begin
    rem_sh = {rem, dvd[XLEN-1]};
    ge     = (rem_sh >= {1'b0, dvs});
    rem_nx = ge ? (rem_sh[XLEN-1:0] - dvs) : rem_sh[XLEN-1:0];
    q_fix  = neg_q ? -dvd : dvd;
    r_fix  = neg_r ? -rem : rem;
    res    = op_rem ? r_fix : q_fix;
    if (op_w) res = ext32(res[31:0], 1'b1);
  end

  // Control FSM and datapath registers; special cases preload dvd/rem with the final q/r.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      dvd            <= '0;
      dvs            <= '0;
      rem            <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      op_w           <= 1'b0;
      op_rem         <= 1'b0;
      bus.div_stall  <= 1'b0;
      bus.div_bubble <= 1'b1;
      bus.div_r      <= '0;
    end else begin
      bus.div_bubble <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!bus.ex_stall && !bus.id_bubble && dec.is_div) begin
            op_w          <= dec.w;
            op_rem        <= dec.rem;
            bus.div_stall <= 1'b1;
            if (dz) begin
              dvd   <= '1;
              rem   <= a_ext;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= ST_DONE;
            end else if (ovf) begin
              dvd   <= a_ext;
              rem   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= ST_DONE;
            end else begin
              // W ops are left-aligned so the step always consumes dvd's MSB.
              dvd   <= dec.w ? (a_mag << (XLEN - 32)) : a_mag;
              dvs   <= b_mag;
              rem   <= '0;
              neg_q <= s_a ^ s_b;
              neg_r <= s_a;
              cnt   <= dec.w ? CW'(31) : CW'(XLEN - 1);
              state <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          dvd <= {dvd[XLEN-2:0], ge};
          rem <= rem_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= ST_DONE;
        end
        ST_DONE: begin
          bus.div_r      <= res;
          bus.div_bubble <= 1'b0;
          bus.div_stall  <= 1'b0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
